// File: rtl/audio_track_sequencer.sv
// audio_track_sequencer: turns record/play/stop commands into sample-paced single-word RAM requests with playback volume.
// Define OVERRUN_CNT_EN to add the overrun_cnt output counting samples dropped while a write is stalled.
module audio_track_sequencer #(
   parameter int ADDR_W = 26,
   parameter int DATA_W = 16,
   parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_rec,
   input  logic              cmd_play,
   input  logic              cmd_stop,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic [2:0]        volume,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              dac_req,
   output logic [DATA_W-1:0] dac_sample,
   output logic              dac_valid,
   input  logic              ram_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wr_req,
   output logic              ram_rd_req,
   input  logic              ram_ack,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              done,
   output logic              mem_full,
   output logic [ADDR_W-1:0] rec_end_addr
`ifdef OVERRUN_CNT_EN
   ,
   output logic [15:0]       overrun_cnt
`endif
);
   typedef enum logic [2:0] {IDLE, REC_WAIT, REC_WRITE, PLAY_FETCH, PLAY_HOLD} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] cur_addr, end_reg, addr_inc;
   logic stop_pend, stop_any, done_n, accept, hold_take;
   logic signed [DATA_W-1:0] scaled;
   assign addr_inc = cur_addr + ADDR_W'(1);
   assign stop_any = stop_pend | cmd_stop;
   assign accept = state == IDLE && ram_ready && !cmd_stop && (cmd_rec || cmd_play);
   assign hold_take = state == PLAY_HOLD && !cmd_stop && dac_req;
   assign scaled = $signed(ram_rdata) >>> (3'd7 - volume);
   assign ram_wr_req = state == REC_WRITE;
   assign ram_rd_req = state == PLAY_FETCH;
   assign busy = state != IDLE;
   always_comb begin
      state_n = state;
      done_n = 1'b0;
      case (state)
         IDLE: begin
            if (accept && cmd_rec) state_n = REC_WAIT;
            else if (accept) begin
               done_n = start_addr == end_addr;
               state_n = done_n ? IDLE : PLAY_FETCH;
            end
         end
         REC_WAIT: begin
            done_n = cmd_stop;
            state_n = cmd_stop ? IDLE : (sample_valid ? REC_WRITE : REC_WAIT);
         end
         REC_WRITE: if (ram_ack) begin
            done_n = cur_addr == MAX_ADDR || stop_any;
            state_n = done_n ? IDLE : REC_WAIT;
         end
         PLAY_FETCH: if (ram_ack) begin
            done_n = stop_any;
            state_n = stop_any ? IDLE : PLAY_HOLD;
         end
         PLAY_HOLD: begin
            if (cmd_stop) begin
               done_n = 1'b1;
               state_n = IDLE;
            end else if (dac_req) begin
               done_n = addr_inc == end_reg;
               state_n = done_n ? IDLE : PLAY_FETCH;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         done <= 1'b0;
         dac_valid <= 1'b0;
         dac_sample <= '0;
         ram_addr <= '0;
         ram_wdata <= '0;
         rec_end_addr <= '0;
         mem_full <= 1'b0;
         cur_addr <= '0;
         end_reg <= '0;
         stop_pend <= 1'b0;
`ifdef OVERRUN_CNT_EN
         overrun_cnt <= '0;
`endif
      end else begin
         state <= state_n;
         done <= done_n;
         dac_valid <= hold_take;
         if (accept) begin
            cur_addr <= start_addr;
            end_reg <= end_addr;
            stop_pend <= 1'b0;
            if (!cmd_rec) ram_addr <= start_addr;
         end
         if (accept && cmd_rec) begin
            mem_full <= 1'b0;
`ifdef OVERRUN_CNT_EN
            overrun_cnt <= '0;
`endif
         end
         if (state == REC_WAIT && cmd_stop) rec_end_addr <= cur_addr;
         if (state == REC_WAIT && !cmd_stop && sample_valid) begin
            ram_addr <= cur_addr;
            ram_wdata <= sample_in;
         end
         if (state == REC_WRITE || state == PLAY_FETCH) stop_pend <= stop_any;
`ifdef OVERRUN_CNT_EN
         if (state == REC_WRITE && sample_valid && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
`endif
         // the final word marks the memory full regardless of any pending stop
         if (state == REC_WRITE && ram_ack && cur_addr == MAX_ADDR) begin
            mem_full <= 1'b1;
            rec_end_addr <= MAX_ADDR;
         end else if (state == REC_WRITE && ram_ack) begin
            cur_addr <= addr_inc;
            if (stop_any) rec_end_addr <= addr_inc;
         end
         if (state == PLAY_FETCH && ram_ack) dac_sample <= scaled;
         if (hold_take) begin
            cur_addr <= addr_inc;
            ram_addr <= addr_inc;
         end
      end
   end
endmodule

// File: tb/tb_audio_track_sequencer.sv
// tb_audio_track_sequencer: directed checks of record, mem-full, playback with volume, stop and empty-track cases.
module tb_audio_track_sequencer;
   logic clk = 1'b0;
   logic reset, cmd_rec, cmd_play, cmd_stop, sample_valid, dac_req, ram_ready, ram_ack;
   logic [25:0] start_addr, end_addr;
   logic [2:0] volume;
   logic [15:0] sample_in, ram_rdata;
   logic [15:0] dac_sample, ram_wdata;
   logic dac_valid, ram_wr_req, ram_rd_req, busy, done, mem_full;
   logic [25:0] ram_addr, rec_end_addr;
`ifdef OVERRUN_CNT_EN
   logic [15:0] overrun_cnt;
`endif
   int n_chk = 0;
   int n_fail = 0;
   logic [15:0] smp [3];
   logic [15:0] exp5 [3];

   audio_track_sequencer dut (
      .clk(clk), .reset(reset), .cmd_rec(cmd_rec), .cmd_play(cmd_play), .cmd_stop(cmd_stop),
      .start_addr(start_addr), .end_addr(end_addr), .volume(volume),
      .sample_valid(sample_valid), .sample_in(sample_in), .dac_req(dac_req),
      .dac_sample(dac_sample), .dac_valid(dac_valid), .ram_ready(ram_ready),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wr_req(ram_wr_req), .ram_rd_req(ram_rd_req),
      .ram_ack(ram_ack), .ram_rdata(ram_rdata), .busy(busy), .done(done), .mem_full(mem_full),
`ifdef OVERRUN_CNT_EN
      .overrun_cnt(overrun_cnt),
`endif
      .rec_end_addr(rec_end_addr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      smp[0] = 16'h1234; smp[1] = 16'h8000; smp[2] = 16'h7FFF;
      exp5[0] = 16'h048D; exp5[1] = 16'hE000; exp5[2] = 16'h1FFF;
      reset = 1'b1; cmd_rec = 0; cmd_play = 0; cmd_stop = 0; sample_valid = 0; dac_req = 0;
      ram_ready = 1'b1; ram_ack = 0; start_addr = '0; end_addr = '0; volume = 3'd7;
      sample_in = '0; ram_rdata = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_wr", ram_wr_req, 0);
      chk("rst_rd", ram_rd_req, 0);
      chk("rst_done", done, 0);
      chk("rst_full", mem_full, 0);
      chk("rst_end", rec_end_addr, 0);
      chk("rst_dac", dac_sample, 0);
      chk("rst_addr", ram_addr, 0);

      // commands ignored while memory not ready
      ram_ready = 1'b0; cmd_rec = 1'b1; start_addr = 26'h50;
      tick();
      cmd_rec = 1'b0; ram_ready = 1'b1;
      chk("notready_busy", busy, 0);

      // reset in the middle of a write
      cmd_rec = 1'b1;
      tick();
      cmd_rec = 1'b0;
      chk("r1_busy", busy, 1);
      sample_valid = 1'b1; sample_in = 16'hAAAA;
      tick();
      sample_valid = 1'b0;
      chk("r1_wr", ram_wr_req, 1);
      chk("r1_addr", ram_addr, 26'h50);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("r1_wr_after", ram_wr_req, 0);
      chk("r1_busy_after", busy, 0);
      ram_ack = 1'b1;
      tick();
      ram_ack = 1'b0;
      tick();
      chk("r1_late_ack_busy", busy, 0);
      chk("r1_late_ack_done", done, 0);
      chk("r1_late_ack_end", rec_end_addr, 0);

      // record three samples at 0x100 then stop
      cmd_rec = 1'b1; start_addr = 26'h100;
      tick();
      cmd_rec = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample_valid = 1'b1; sample_in = smp[k];
         tick();
         sample_valid = 1'b0;
         chk("rec_wr", ram_wr_req, 1);
         chk("rec_addr", ram_addr, 26'h100 + k);
         chk("rec_wdata", ram_wdata, smp[k]);
         tick();
         chk("rec_wr_hold", ram_wr_req, 1);
         ram_ack = 1'b1;
         tick();
         ram_ack = 1'b0;
         chk("rec_wr_drop", ram_wr_req, 0);
         chk("rec_busy", busy, 1);
         chk("rec_nodone", done, 0);
      end
      cmd_stop = 1'b1;
      tick();
      cmd_stop = 1'b0;
      chk("rec_done", done, 1);
      chk("rec_idle", busy, 0);
      chk("rec_end", rec_end_addr, 26'h103);
      tick();
      chk("rec_done_pulse", done, 0);

      // record at the top of memory
      cmd_rec = 1'b1; start_addr = 26'h3FFFFFE;
      tick();
      cmd_rec = 1'b0;
      for (int k = 0; k < 2; k++) begin
         sample_valid = 1'b1; sample_in = smp[k];
         tick();
         sample_valid = 1'b0;
         chk("full_addr", ram_addr, 26'h3FFFFFE + k);
         if (k == 1) begin
            // two overrun samples while the write stalls
            sample_valid = 1'b1; sample_in = 16'h5555;
            tick();
            sample_valid = 1'b0;
            tick();
            sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
            chk("overrun_wdata", ram_wdata, smp[1]);
            chk("overrun_wr", ram_wr_req, 1);
         end
         ram_ack = 1'b1;
         tick();
         ram_ack = 1'b0;
         if (k == 0) chk("full_notyet", mem_full, 0);
      end
      chk("full_flag", mem_full, 1);
      chk("full_done", done, 1);
      chk("full_busy", busy, 0);
      chk("full_end", rec_end_addr, 26'h3FFFFFF);
`ifdef OVERRUN_CNT_EN
      chk("overrun_cnt", overrun_cnt, 2);
`endif
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      chk("full_third_wr", ram_wr_req, 0);
      chk("full_third_busy", busy, 0);

      // playback at unity then volume 5
      for (int v = 0; v < 2; v++) begin
         volume = (v == 0) ? 3'd7 : 3'd5;
         cmd_play = 1'b1; start_addr = 26'h100; end_addr = 26'h103;
         tick();
         cmd_play = 1'b0;
         for (int k = 0; k < 3; k++) begin
            chk("play_rd", ram_rd_req, 1);
            chk("play_nowr", ram_wr_req, 0);
            chk("play_addr", ram_addr, 26'h100 + k);
            tick();
            ram_ack = 1'b1; ram_rdata = smp[k];
            tick();
            ram_ack = 1'b0; ram_rdata = 16'h0F0F;
            chk("play_rd_drop", ram_rd_req, 0);
            chk("play_novalid", dac_valid, 0);
            dac_req = 1'b1;
            tick();
            dac_req = 1'b0;
            chk("play_valid", dac_valid, 1);
            chk("play_sample", dac_sample, (v == 0) ? smp[k] : exp5[k]);
            chk("play_done", done, k == 2);
            tick();
            chk("play_valid_pulse", dac_valid, 0);
         end
         chk("play_idle", busy, 0);
      end
      chk("full_sticky", mem_full, 1);

      // stop while holding a sample beats a simultaneous dac_req
      volume = 3'd7; cmd_play = 1'b1;
      tick();
      cmd_play = 1'b0;
      ram_ack = 1'b1; ram_rdata = 16'h4321;
      tick();
      ram_ack = 1'b0;
      cmd_stop = 1'b1; dac_req = 1'b1;
      tick();
      cmd_stop = 1'b0; dac_req = 1'b0;
      chk("stop_hold_valid", dac_valid, 0);
      chk("stop_hold_done", done, 1);
      chk("stop_hold_busy", busy, 0);

      // stop pending during fetch ends on ack without a dac strobe
      cmd_play = 1'b1;
      tick();
      cmd_play = 1'b0;
      cmd_stop = 1'b1;
      tick();
      cmd_stop = 1'b0;
      chk("stop_fetch_rd", ram_rd_req, 1);
      ram_ack = 1'b1;
      tick();
      ram_ack = 1'b0;
      chk("stop_fetch_done", done, 1);
      chk("stop_fetch_busy", busy, 0);
      chk("stop_fetch_valid", dac_valid, 0);

      // empty track
      cmd_play = 1'b1; start_addr = 26'h200; end_addr = 26'h200;
      tick();
      cmd_play = 1'b0;
      chk("empty_done", done, 1);
      chk("empty_rd", ram_rd_req, 0);
      chk("empty_busy", busy, 0);
      tick();
      chk("empty_done_pulse", done, 0);

      // new recording clears mem_full
      cmd_rec = 1'b1; start_addr = 26'h10;
      tick();
      cmd_rec = 1'b0;
      chk("rec_clear_full", mem_full, 0);
`ifdef OVERRUN_CNT_EN
      chk("rec_clear_overrun", overrun_cnt, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/audio_track_sequencer.md
Name: audio_track_sequencer

Overview:
- Sits between the menu FSM and the DDR memory interface / audio codec path.
- Converts record/play/stop commands plus a track start address into a stream of single-word RAM write or read requests paced by codec sample strobes.
- Applies the 3-bit volume to playback samples.
- Reports track end address, memory-full and done back to the menu FSM.

Parameters:
- ADDR_W, 26, RAM word address width.
- DATA_W, 16, audio sample width (two's complement).
- MAX_ADDR, 26'h3FFFFFF, last writable word address; a write here sets mem_full.

Ports:
- clk  in  1  system clock (the PicoBlaze-domain clock).
- reset  in  1  synchronous, active-high.
- cmd_rec  in  1  start recording at start_addr (one-cycle pulse).
- cmd_play  in  1  start playback from start_addr to end_addr (pulse).
- cmd_stop  in  1  stop current operation (pulse).
- start_addr  in  ADDR_W  first word of the track.
- end_addr  in  ADDR_W  playback stop address (exclusive).
- volume  in  3  0 = quietest, 7 = unity gain.
- sample_valid  in  1  ADC sample strobe, one cycle.
- sample_in  in  DATA_W  ADC sample.
- dac_req  in  1  DAC requests the next sample, one cycle.
- dac_sample  out  DATA_W  scaled playback sample.
- dac_valid  out  1  one-cycle strobe qualifying dac_sample.
- ram_ready  in  1  memory interface calibrated/idle (status).
- ram_addr  out  ADDR_W  request address.
- ram_wdata  out  DATA_W  write data.
- ram_wr_req  out  1  write request, level.
- ram_rd_req  out  1  read request, level.
- ram_ack  in  1  one-cycle completion of the current request.
- ram_rdata  in  DATA_W  read data, valid with ram_ack.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse at end of any operation.
- mem_full  out  1  sticky; cleared by reset or the next cmd_rec.
- rec_end_addr  out  ADDR_W  next free address after the last recording.

Behaviour:
- Reset, effective next edge even mid-request: state IDLE; all outputs 0 (dac_sample, ram_addr, ram_wdata, rec_end_addr all 0). Any outstanding ram_ack after reset is ignored.
- States: IDLE, REC_WAIT, REC_WRITE, PLAY_FETCH, PLAY_HOLD.
- Command priority: stop > rec > play.
  - Commands in IDLE only, and only when ram_ready=1; otherwise ignored.
  - cmd_rec/cmd_play while busy are ignored.
- IDLE + cmd_rec: cur_addr <= start_addr, mem_full <= 0, go REC_WAIT.
- REC_WAIT:
  - sample_valid: latch sample_in into ram_wdata, ram_addr <= cur_addr, ram_wr_req=1 next cycle, go REC_WRITE.
  - cmd_stop: rec_end_addr <= cur_addr, done pulse, go IDLE.
- REC_WRITE: hold wr_req/addr/wdata stable until ram_ack. On ack:
  - drop wr_req the same edge.
  - if cur_addr == MAX_ADDR: mem_full <= 1, rec_end_addr <= MAX_ADDR, done, IDLE.
  - else cur_addr++, then IDLE if a stop was pending (rec_end_addr = new cur_addr, done), otherwise REC_WAIT.
  - sample_valid during REC_WRITE = overrun; that sample is dropped.
  - cmd_stop during REC_WRITE is latched as pending; the write always completes.
- IDLE + cmd_play:
  - start_addr == end_addr: done next cycle, stay IDLE, no RAM traffic.
  - otherwise cur_addr <= start_addr, end <= end_addr, go PLAY_FETCH.
- PLAY_FETCH: ram_rd_req=1, ram_addr=cur_addr until ram_ack. On ack:
  - register scaled sample, go PLAY_HOLD.
  - a pending stop then gives done and IDLE, with no dac_valid.
- PLAY_HOLD, on dac_req:
  - dac_valid=1 for exactly one cycle with the held sample, cur_addr++ (mod 2^ADDR_W).
  - if new cur_addr == end: done, IDLE; else PLAY_FETCH.
  - cmd_stop in PLAY_HOLD: done, IDLE immediately, no dac_valid.
- Latency:
  - sample_valid to ram_wr_req: 1 cycle.
  - ram_ack to ram_rd_req deasserted: same edge.
  - dac_req to dac_valid: 1 cycle.
- Volume: dac_sample = ram_rdata >>> (7 - volume), arithmetic shift; sign is preserved. volume is sampled at ram_ack.
- ram_wr_req and ram_rd_req are never high together. Neither is dropped before ack except by reset.
- busy = (state != IDLE).

Optional Feature:
- OVERRUN_CNT_EN defined:
  - adds output overrun_cnt[15:0], counting samples dropped in REC_WRITE.
  - saturates at 16'hFFFF.
  - cleared by reset and by accepted cmd_rec.
- Undefined: the port is absent and overruns are silently dropped.

Test Plan:
- Reset in REC_WRITE with ram_wr_req=1 -> next cycle ram_wr_req=0, busy=0; a later ram_ack causes no effect.
- cmd_rec at start_addr=0x100, 3 samples 0x1234/0x8000/0x7FFF, ack 2 cycles after each req, then cmd_stop -> writes to 0x100..0x102 with that data, rec_end_addr=0x103, one done pulse.
- cmd_rec at start_addr=MAX_ADDR-1, 3 samples -> 2 writes, mem_full=1, done, third sample ignored, busy=0.
- cmd_play 0x100..0x103, volume=7, rdata 0x1234/0x8000/0x7FFF -> 3 dac_valid pulses with identical values; done after third.
- Same playback with volume=5 -> dac_sample 0x048D, 0xE000, 0x1FFF.
- cmd_play with start=end=0x200 -> done next cycle, no rd_req. With OVERRUN_CNT_EN: 2 sample_valid during one write stall -> overrun_cnt=2.
